// File: rtl/fifo.sv
// fifo: single-clock synchronous FIFO with registered read data.
//
// Parameters:
//   DATAWIDTH - width of each stored word
//   DEPTH     - number of entries (power of two, >= 2)
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rstn      - asynchronous reset, ACTIVE-HIGH despite the name
//   dataIn    - write data, captured when a write is accepted
//   WR        - write request (level-sensitive, one word per cycle)
//   full      - high when DEPTH entries are stored
//   dataOut   - registered read data, holds when no read is accepted
//   empty     - high when no entries are stored
//   RD        - read request (level-sensitive, one word per cycle)
//
// Optional feature (macro FIFO_ERR_FLAGS_EN):
//   overflow  - sticky, set by a write attempt while full that is not
//               accompanied by an accepted read
//   underflow - sticky, set by a read attempt while empty
//   Both clear only on reset. Without the macro these ports do not exist.

module fifo #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATAWIDTH-1:0] dataIn,
  input  logic                 WR,
  output logic                 full,
  output logic [DATAWIDTH-1:0] dataOut,
  output logic                 empty,
  input  logic                 RD
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;

  logic wr_ok;
  logic rd_ok;

  // Flags come straight from the registered count, so they move on the
  // same edge as the count.
  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // Accept decisions use pre-edge state: a write while full is dropped even
  // if a read is accepted on the same edge.
  assign wr_ok = WR & ~full;
  assign rd_ok = RD & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;

    // Pointer width equals log2(DEPTH), so the natural overflow is the wrap.
    if (wr_ok) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + AW'(1);
      dout_d = mem_q[rptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= dataIn;
    end
  end

  assign dataOut = dout_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // When full the FIFO is non-empty, so an accepted read rescues the write
  // attempt from being counted as an overflow.
  always_comb begin
    overflow_d  = overflow_q | (WR & full & ~rd_ok);
    underflow_d = underflow_q | (RD & empty);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed scenarios plus randomized traffic against a queue-based
// reference model of the FIFO. Outputs are sampled 1 ns after each rising edge.

module tb_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] dataIn;
  logic          WR;
  logic          RD;
  logic          full;
  logic          empty;
  logic [DW-1:0] dataOut;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo #(
    .DATAWIDTH(DW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .dataIn   (dataIn),
    .WR       (WR),
    .full     (full),
    .dataOut  (dataOut),
    .empty    (empty),
    .RD       (RD)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Reference model: contents as a queue, plus expected output registers.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dataOut"}, 32'(dataOut), 32'(exp_dout));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // One clock of traffic: drive on the falling edge, update the model with
  // the pre-edge view at the rising edge, then compare.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din, input string tag);
    bit was_full;
    bit was_empty;
    bit wr_acc;
    bit rd_acc;
    @(negedge clk);
    WR     = wr;
    RD     = rd;
    dataIn = din;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    wr_acc    = wr && !was_full;
    rd_acc    = rd && !was_empty;
    if (wr && was_full && !rd_acc) exp_ovf = 1'b1;
    if (rd && was_empty) exp_unf = 1'b1;
    if (rd_acc) exp_dout = model_q.pop_front();
    if (wr_acc) model_q.push_back(din);
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  // Reset asserted between clock edges; its effect must be visible before
  // the next rising edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    WR   = 1'b0;
    RD   = 1'b0;
    rstn = 1'b1;
    model_reset();
    #1;
    check_outputs({tag, ".async"});
    #10;
    rstn = 1'b0;
    @(negedge clk);
    check_outputs({tag, ".release"});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, n_vec %0d", n_vec);
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rstn   = 1'b1;
    WR     = 1'b0;
    RD     = 1'b0;
    dataIn = '0;
    model_reset();

    // Reset state, held for 10 ns then released mid-cycle.
    #1;
    check_outputs("reset");
    #10;
    rstn = 1'b0;
    @(negedge clk);
    check_outputs("reset_release");

    // Fill, then one write while full.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(i), "fill");
    step(1'b1, 1'b0, 8'd4, "fill_over");

    // Drain, then one read while empty.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, "drain");
    step(1'b0, 1'b1, '0, "drain_under");
    check("drain_hold_value", 32'(dataOut), 32'd3);

    // Pointer wrap.
    pulse_reset("pre_wrap");
    for (int i = 10; i < 13; i++) step(1'b1, 1'b0, DW'(i), "wrap_wr1");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, '0, "wrap_rd1");
    for (int i = 13; i < 16; i++) step(1'b1, 1'b0, DW'(i), "wrap_wr2");
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, "wrap_rd2");
    check("wrap_last", 32'(dataOut), 32'd15);

    // Simultaneous read and write: mid-occupancy, full, and empty.
    step(1'b1, 1'b0, 8'd5, "sim_setup");
    step(1'b1, 1'b0, 8'd6, "sim_setup");
    step(1'b1, 1'b1, 8'd7, "sim_mid");
    check("sim_mid_dout", 32'(dataOut), 32'd5);
    step(1'b1, 1'b0, 8'd8, "sim_fill");
    step(1'b1, 1'b0, 8'd9, "sim_fill");
    step(1'b1, 1'b1, 8'd20, "sim_full");
    check("sim_full_drop", 32'(full), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "sim_drain");
    step(1'b1, 1'b1, 8'd21, "sim_empty");
    step(1'b0, 1'b1, '0, "sim_empty_rd");

    // Async reset with three entries held, then a round trip.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(30 + i), "mid_fill");
    pulse_reset("mid_reset");
    step(1'b1, 1'b0, 8'd9, "post_reset_wr");
    step(1'b0, 1'b1, '0, "post_reset_rd");
    check("post_reset_val", 32'(dataOut), 32'd9);

    // Randomized traffic with varying read/write bias.
    for (int i = 0; i < 1500; i++) begin
      int unsigned bias;
      bias = (i / 250) % 3;
      step(($urandom_range(0, 3) < (bias + 1)),
           ($urandom_range(0, 3) < (3 - bias)),
           DW'($urandom), "rand");
      if ($urandom_range(0, 299) == 0) pulse_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO buffer with parameterised width and depth.
- Writes are accepted while not full and reads are accepted while not empty.
- Status flags `full` and `empty` are provided.
- Read data is registered.
- Used as a generic elastic buffer between producer and consumer logic in the same clock domain.

Parameters:
- DATAWIDTH, 8, width in bits of each stored word.
- DEPTH, 4, number of storage entries; must be a power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset.
  - Asynchronous, active-high: rstn=1 resets.
  - Name kept per codebase convention; polarity is high despite the name.
- dataIn  input  DATAWIDTH  write data, sampled on the clk edge when the write is accepted.
- WR  input  1  write request.
- full  output  1  high when DEPTH entries are stored.
- dataOut  output  DATAWIDTH  registered read data.
- empty  output  1  high when 0 entries are stored.
- RD  input  1  read request.

Behaviour:
- Storage:
  - DEPTH x DATAWIDTH memory.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter, log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (rstn=1, asynchronous, takes effect immediately):
  - Pointers = 0, count = 0.
  - empty=1, full=0, dataOut=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data.
- Flags:
  - empty = (count==0).
  - full = (count==DEPTH).
  - Both are registered/derived from registered count, and change in the same cycle as the count update.
- Accept conditions (evaluated on pre-edge state):
  - wr_ok = WR & ~full.
  - rd_ok = RD & ~empty.
- Write: on wr_ok, mem[wptr] <= dataIn, then wptr increments with wrap.
- Read:
  - On rd_ok, dataOut <= mem[rptr], then rptr increments with wrap.
  - Latency: data is visible on dataOut after the edge at which RD is sampled.
  - dataOut holds its last value when no read is accepted.
- Count update:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - Both, or neither: unchanged.
- Simultaneous WR & RD:
  - When full: only the read is accepted; the write is dropped, and count becomes DEPTH-1.
  - When empty: only the write is accepted; dataOut is unchanged (no fall-through).
  - Otherwise both are accepted.
- Write while full: ignored; no state change, data lost.
- Read while empty: ignored; dataOut unchanged.
- Ordering: strict first-in first-out; pointer wrap is transparent to the user.
- WR and RD are level-sensitive: one transfer per clock per asserted cycle.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds output ports overflow (1 bit) and underflow (1 bit).
  - overflow sets on any edge with WR & full and ~rd_ok.
  - underflow sets on any edge with RD & empty.
  - Both flags are sticky and cleared only by reset (value 0).
- Undefined: the ports and logic are absent; the interface is exactly as listed above.

Test Plan:
- Reset: assert rstn=1 for 10 ns, with clk period 4 ns -> empty=1, full=0, dataOut=0; reset release leaves these values unchanged.
- Fill: write 0,1,2,3 on consecutive cycles -> full=1 after the 4th write edge, empty=0; a 5th write with dataIn=4 is ignored and full stays 1.
- Drain: RD for 4 cycles -> dataOut = 0,1,2,3 in order, each valid after its read edge; empty=1 after the 4th; a further RD leaves dataOut=3.
- Wrap: write 10,11,12, read 2, write 13,14,15, then read 4 -> dataOut = 10,11,12,13,14,15 in order; full asserts after 15 is written.
- Simultaneous: with 2 entries held (5,6), assert WR=1 (dataIn=7) and RD=1 -> dataOut=5, count stays 2, empty=0 and full=0; when full, WR+RD -> only the read is accepted and full drops to 0.
- Async reset mid-stream: with 3 entries held, pulse rstn=1 between clock edges -> empty=1 immediately; a subsequent write/read of 9 returns 9.
- With FIFO_ERR_FLAGS_EN defined:
  - A write when full sets overflow=1.
  - A read when empty sets underflow=1.
  - Both flags hold until reset.
